narrow32t16: RTL and testbench

- Pipelined 32-to-16 narrowing unit; the inverse direction of the 16-to-32 sign/zero extender.
- Converts a 32-bit value X to a 16-bit Y under a signedness select B (B=1 signed, B=0 unsigned), detecting out-of-range values.
- Sits on the store/ALU-result path wherever a word must be written back as a halfword.
- Uses valid/ready handshakes with a 2-stage pipeline and a saturating overflow-event counter.

---
 rtl/narrow32t16_pkg.sv | 22 ++
 rtl/narrow32t16_if.sv | 36 +++
 rtl/narrow32t16_range_chk.sv | 48 ++++
 rtl/narrow32t16.sv | 111 +++++++++++
 tb/tb_narrow32t16.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/narrow32t16_pkg.sv
// ============================================================================
// narrow32t16_pkg : shared widths, signedness encoding and halfword limits
// Rev 1.0
// ============================================================================
`default_nettype none

package narrow32t16_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  // Signedness select encoding, common to the narrowing and extending units
  localparam logic SIGNED   = 1'b1;
  localparam logic UNSIGNED = 1'b0;

  localparam logic [HALF_W-1:0] HALF_SMAX = 16'h7FFF;
  localparam logic [HALF_W-1:0] HALF_SMIN = 16'h8000;
  localparam logic [HALF_W-1:0] HALF_UMAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/narrow32t16_if.sv
// ============================================================================
// narrow32t16_if : input/output handshake bundle of the narrowing unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface narrow32t16_if #(
  parameter int IN_W  = narrow32t16_pkg::WORD_W,
  parameter int OUT_W = narrow32t16_pkg::HALF_W,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  X;
  logic             B;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] Y;
  logic             ovf;
  logic             cnt_clr;
  logic [CNT_W-1:0] ovf_cnt;

  modport slave (
    input  in_valid, X, B, out_ready, cnt_clr,
    output in_ready, out_valid, Y, ovf, ovf_cnt
  );

  modport master (
    output in_valid, X, B, out_ready, cnt_clr,
    input  in_ready, out_valid, Y, ovf, ovf_cnt
  );

endinterface

`default_nettype wire

// File: rtl/narrow32t16_range_chk.sv
// ============================================================================
// narrow_range_chk : combinational range check and overflow value for a
// word-to-halfword narrowing. NARROW_SATURATE_EN selects clamping on overflow.
// Rev 1.0
// ============================================================================
`default_nettype none

module narrow_range_chk #(
  parameter int IN_W  = narrow32t16_pkg::WORD_W,
  parameter int OUT_W = narrow32t16_pkg::HALF_W
) (
  input  logic [IN_W-1:0]  x,
  input  logic             b,
  output logic             in_range,
  output logic [OUT_W-1:0] clamp
);
  import narrow32t16_pkg::*;

  localparam logic [OUT_W-1:0] C_SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] C_SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] C_UMAX = {OUT_W{1'b1}};

  logic [IN_W-OUT_W:0]   upper_s;
  logic [IN_W-OUT_W-1:0] upper_u;

  assign upper_s = x[IN_W-1:OUT_W-1];
  assign upper_u = x[IN_W-1:OUT_W];

  always_comb begin
    in_range = 1'b0;
    clamp    = x[OUT_W-1:0];
    if (b == SIGNED) begin
      in_range = (&upper_s) | ~(|upper_s);
    end else begin
      in_range = ~(|upper_u);
    end
`ifdef NARROW_SATURATE_EN
    if (b == SIGNED) begin
      clamp = x[IN_W-1] ? C_SMIN : C_SMAX;
    end else begin
      clamp = C_UMAX;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/narrow32t16.sv
// ============================================================================
// narrow32t16 : two-stage valid/ready 32-to-16 narrowing pipeline with a
// saturating overflow-event counter. Build option: NARROW_SATURATE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module narrow32t16 #(
  parameter int IN_W  = narrow32t16_pkg::WORD_W,
  parameter int OUT_W = narrow32t16_pkg::HALF_W,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  narrow32t16_if.slave  bus
);
  import narrow32t16_pkg::*;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic             b_q, b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_load;
  logic             accept;
  logic             out_fire;
  logic             in_range;
  logic [OUT_W-1:0] clamp;

  narrow_range_chk #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_range_chk (
    .x        (x_q),
    .b        (b_q),
    .in_range (in_range),
    .clamp    (clamp)
  );

  // in_ready looks straight through out_ready so a full pipe still streams
  assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign bus.in_ready = rst_n && (!s1_valid_q || s2_load);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = s2_valid_q && bus.out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      x_d        = bus.X;
      b_d        = bus.B;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      y_d        = in_range ? x_q[OUT_W-1:0] : clamp;
      ovf_d      = !in_range;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    // Clear has priority over a coincident overflow delivery
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire && ovf_q && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      b_q        <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      x_q        <= x_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.Y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.ovf_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_narrow32t16.sv
// ============================================================================
// tb_narrow32t16 : directed vector table plus hand-written stall, counter and
// reset sequences for narrow32t16, with an in-order output scoreboard.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_narrow32t16;
  import narrow32t16_pkg::*;

  logic clk;
  logic rst_n;

  narrow32t16_if #(.IN_W(32), .OUT_W(16), .CNT_W(8)) bus ();

  narrow32t16 #(.IN_W(32), .OUT_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic        b;
    logic [15:0] y_sat;
    logic [15:0] y_trn;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;
  int   out_cnt  = 0;
  bit   lat_chk  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Independent reference: range judged by signed/unsigned magnitude compare
  task automatic model(input logic [31:0] x, input logic b,
                       output logic [15:0] y, output logic o);
    if (b) o = ($signed(x) > 32767) || ($signed(x) < -32768);
    else   o = (x > 32'd65535);
    y = x[15:0];
`ifdef NARROW_SATURATE_EN
    if (o) begin
      if (b) y = ($signed(x) < 0) ? HALF_SMIN : HALF_SMAX;
      else   y = HALF_UMAX;
    end
`endif
  endtask

  task automatic cycle(input logic vld, input logic [31:0] x, input logic b,
                       input logic [15:0] ey, input logic eo,
                       input logic ordy, input logic clr,
                       output logic acc, output logic fire);
    exp_t e;
    bus.in_valid  = vld;
    bus.X         = x;
    bus.B         = b;
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    @(negedge clk);
    acc  = bus.in_valid && bus.in_ready;
    fire = bus.out_valid && bus.out_ready;
    if (fire) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("Y", {16'd0, bus.Y}, {16'd0, e.y});
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
        if (lat_chk) chk("latency", 32'(cyc_n - e.cyc), 32'd2);
      end
    end
    if (acc) exp_q.push_back('{y: ey, ovf: eo, cyc: cyc_n});
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drain();
    logic a, f;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      cycle(1'b0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, a, f);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic        acc, fire, eo;
    logic [15:0] ey, held_y;
    logic [31:0] x;
    int          idx, guard, base_out;

    vecs[0] = '{32'h0000_1234, 1'b1, 16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{32'hFFFF_8000, 1'b1, 16'h8000, 16'h8000, 1'b0};
    vecs[2] = '{32'h0000_FFFF, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3] = '{32'h0000_7FFF, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[4] = '{32'h0000_8000, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
    vecs[5] = '{32'h8000_0000, 1'b1, 16'h8000, 16'h0000, 1'b1};
    vecs[6] = '{32'h0001_0005, 1'b0, 16'hFFFF, 16'h0005, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[9] = '{32'hFFFF_7FFF, 1'b1, 16'h8000, 16'h7FFF, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.X         = 32'h0;
    bus.B         = 1'b0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
    @(negedge clk);
    chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_Y", {16'd0, bus.Y}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_ovf_cnt", {24'd0, bus.ovf_cnt}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back table, out_ready held high, fixed 2-cycle latency
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef NARROW_SATURATE_EN
      ey = vecs[i].y_sat;
`else
      ey = vecs[i].y_trn;
`endif
      cycle(1'b1, vecs[i].x, vecs[i].b, ey, vecs[i].ovf, 1'b1, 1'b0, acc, fire);
      chk("table_accept", {31'd0, acc}, 32'd1);
    end
    drain();
    lat_chk = 1'b0;
    chk("table_ovf_cnt", {24'd0, bus.ovf_cnt}, 32'd5);

    // Backpressure: five stalled cycles, then release with a random ready pattern
    base_out = out_cnt;
    idx = 0;
    held_y = 16'd0;
    for (int c = 0; c < 5; c++) begin
      x = 32'(idx - 100);
      model(x, idx[0], ey, eo);
      cycle(1'b1, x, idx[0], ey, eo, 1'b0, 1'b0, acc, fire);
      if (acc) idx++;
      if (c == 1) held_y = bus.Y;
      if (c >= 1) begin
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_Y_held", {16'd0, bus.Y}, {16'd0, held_y});
      end
    end
    chk("stall_accepts", 32'(idx), 32'd2);
    guard = 0;
    while (idx < 201 && guard < 2000) begin
      x = 32'(idx - 100);
      model(x, idx[0], ey, eo);
      cycle(1'b1, x, idx[0], ey, eo, ($urandom_range(0, 3) != 0), 1'b0, acc, fire);
      if (acc) idx++;
      guard++;
    end
    chk("stream_all_accepted", 32'(idx), 32'd201);
    drain();
    chk("stream_out_count", 32'(out_cnt - base_out), 32'd201);

    // Counter saturation
    cycle(1'b0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, acc, fire);
    chk("cnt_cleared", {24'd0, bus.ovf_cnt}, 32'd0);
    model(32'h0001_0000, UNSIGNED, ey, eo);
    idx = 0;
    guard = 0;
    while (idx < 300 && guard < 1000) begin
      cycle(1'b1, 32'h0001_0000, UNSIGNED, ey, eo, 1'b1, 1'b0, acc, fire);
      if (acc) idx++;
      guard++;
    end
    drain();
    chk("cnt_saturated", {24'd0, bus.ovf_cnt}, 32'd255);

    // Clear coinciding with an overflowed output transfer
    for (int c = 0; c < 3; c++)
      cycle(1'b1, 32'h0001_0000, UNSIGNED, ey, eo, 1'b1, 1'b0, acc, fire);
    cycle(1'b1, 32'h0001_0000, UNSIGNED, ey, eo, 1'b1, 1'b1, acc, fire);
    chk("clr_coincide_fire", {31'd0, fire}, 32'd1);
    chk("clr_wins", {24'd0, bus.ovf_cnt}, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, acc, fire);
    chk("cnt_after_clr", {24'd0, bus.ovf_cnt}, 32'd1);
    drain();

    // Reset with both stages full: in-flight data must vanish
    cycle(1'b1, 32'h0002_0000, UNSIGNED, ey, eo, 1'b0, 1'b0, acc, fire);
    cycle(1'b1, 32'h0002_0000, UNSIGNED, ey, eo, 1'b0, 1'b0, acc, fire);
    chk("pre_reset_full", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_Y", {16'd0, bus.Y}, 32'd0);
    chk("midrst_ovf_cnt", {24'd0, bus.ovf_cnt}, 32'd0);
    for (int c = 0; c < 4; c++)
      cycle(1'b0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, acc, fire);
    model(32'h0000_0042, SIGNED, ey, eo);
    cycle(1'b1, 32'h0000_0042, SIGNED, ey, eo, 1'b1, 1'b0, acc, fire);
    chk("post_reset_accept", {31'd0, acc}, 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
